// File: rtl/fetch_queue_if.sv
// +----------------------------------------------------------------------+
// | fetch_queue_if: fetch-side and decode-side signal bundle of the      |
// | instruction fetch queue. Rev 1.0                                     |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_queue_if;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr0;
    logic [31:0] in_instr1;
    logic        in_taken0;
    logic        in_taken1;
    logic [31:0] in_target0;
    logic [31:0] in_target1;
    logic        stall;
    logic        out_valid0;
    logic        out_valid1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [31:0] out_instr0;
    logic [31:0] out_instr1;
    logic [31:0] out_target0;
    logic [31:0] out_target1;
    logic        out_taken0;
    logic        out_taken1;
    logic [1:0]  out_take;
    logic        ovf;

    modport master (
        output flush, in_valid, in_pc, in_instr0, in_instr1,
               in_taken0, in_taken1, in_target0, in_target1, out_take,
        input  stall, out_valid0, out_valid1, out_pc0, out_pc1,
               out_instr0, out_instr1, out_target0, out_target1,
               out_taken0, out_taken1, ovf
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr0, in_instr1,
               in_taken0, in_taken1, in_target0, in_target1, out_take,
        output stall, out_valid0, out_valid1, out_pc0, out_pc1,
               out_instr0, out_instr1, out_target0, out_target1,
               out_taken0, out_taken1, ovf
    );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// +----------------------------------------------------------------------+
// | fetch_queue: dual-in / dual-out instruction fetch queue with skid    |
// | back-pressure and flush. Optional FETCH_QUEUE_BYPASS_EN: empty-queue |
// | bypass. Rev 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int SKID  = 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_queue_if.slave fq
);
    localparam int                c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH      = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]     c_STALL_FREE = (c_AW+1)'(2 * (SKID + 1));
    localparam logic [c_AW:0]     c_TWO        = (c_AW+1)'(2);

    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_AW:0]   r_count;
    logic            r_ovf;

    logic [31:0] r_pc     [DEPTH];
    logic [31:0] r_instr  [DEPTH];
    logic        r_taken  [DEPTH];
    logic [31:0] r_target [DEPTH];

    logic [c_AW:0]   w_free;
    logic            w_room;
    logic            w_enq;
    logic            w_drop;
    logic [1:0]      w_enq_n;
    logic [1:0]      w_take_req;
    logic            w_avail_ge1;
    logic            w_avail_ge2;
    logic [1:0]      w_eff_take;
    logic            w_byp;
    logic [c_AW-1:0] w_head1;
    logic [c_AW-1:0] w_tail1;

    assign w_free  = c_DEPTH - r_count;
    assign w_room  = (w_free >= c_TWO);
    assign w_enq   = fq.in_valid & ~fq.flush & w_room;
    assign w_drop  = fq.in_valid & ~fq.flush & ~w_room;
    // A predicted-taken slot 0 makes slot 1 wrong-path, so only one entry goes in
    assign w_enq_n = w_enq ? (fq.in_taken0 ? 2'd1 : 2'd2) : 2'd0;
    assign w_take_req = (fq.out_take == 2'd3) ? 2'd2 : fq.out_take;
    assign w_head1 = r_head + c_AW'(1);
    assign w_tail1 = r_tail + c_AW'(1);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Incoming entries are written at tail == head, so consuming them now is
    // just the normal head advance; taken ones simply never count as stored.
    assign w_byp       = w_enq & (r_count == '0);
    assign w_avail_ge1 = (r_count != '0) | w_byp;
    assign w_avail_ge2 = (r_count >= c_TWO) | (w_byp & (w_enq_n == 2'd2));
`else
    assign w_byp       = 1'b0;
    assign w_avail_ge1 = (r_count != '0);
    assign w_avail_ge2 = (r_count >= c_TWO);
`endif

    always_comb begin
        w_eff_take = 2'd0;
        if (w_avail_ge2) begin
            w_eff_take = w_take_req;
        end else if (w_avail_ge1 && (w_take_req != 2'd0)) begin
            w_eff_take = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (fq.flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + c_AW'(w_eff_take);
                r_tail  <= r_tail + c_AW'(w_enq_n);
                r_count <= r_count + (c_AW+1)'(w_enq_n) - (c_AW+1)'(w_eff_take);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_tail]     <= fq.in_pc;
            r_instr[r_tail]  <= fq.in_instr0;
            r_taken[r_tail]  <= fq.in_taken0;
            r_target[r_tail] <= fq.in_target0;
            if (w_enq_n == 2'd2) begin
                r_pc[w_tail1]     <= fq.in_pc + 32'd4;
                r_instr[w_tail1]  <= fq.in_instr1;
                r_taken[w_tail1]  <= fq.in_taken1;
                r_target[w_tail1] <= fq.in_target1;
            end
        end
    end

    always_comb begin
        fq.out_valid0  = (r_count != '0);
        fq.out_valid1  = (r_count >= c_TWO);
        fq.out_pc0     = r_pc[r_head];
        fq.out_instr0  = r_instr[r_head];
        fq.out_taken0  = r_taken[r_head];
        fq.out_target0 = r_target[r_head];
        fq.out_pc1     = r_pc[w_head1];
        fq.out_instr1  = r_instr[w_head1];
        fq.out_taken1  = r_taken[w_head1];
        fq.out_target1 = r_target[w_head1];
        if (w_byp) begin
            fq.out_valid0  = 1'b1;
            fq.out_valid1  = (w_enq_n == 2'd2);
            fq.out_pc0     = fq.in_pc;
            fq.out_instr0  = fq.in_instr0;
            fq.out_taken0  = fq.in_taken0;
            fq.out_target0 = fq.in_target0;
            fq.out_pc1     = fq.in_pc + 32'd4;
            fq.out_instr1  = fq.in_instr1;
            fq.out_taken1  = fq.in_taken1;
            fq.out_target1 = fq.in_target1;
        end
    end

    assign fq.stall = (w_free < c_STALL_FREE);
    assign fq.ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// +----------------------------------------------------------------------+
// | tb_fetch_queue: directed self-checking bench for fetch_queue         |
// | (DEPTH=16, SKID=2). Rev 1.0                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_queue_if fq ();

    fetch_queue #(.DEPTH(16), .SKID(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [31:0] pc, input logic tk0);
        fq.in_valid   = 1'b1;
        fq.in_pc      = pc;
        fq.in_instr0  = pc ^ 32'hA5A5_0000;
        fq.in_instr1  = pc ^ 32'h5A5A_0004;
        fq.in_taken0  = tk0;
        fq.in_taken1  = 1'b1;
        fq.in_target0 = pc + 32'h0000_0300;
        fq.in_target1 = pc + 32'h0000_0700;
    endtask

    task automatic idle();
        fq.in_valid  = 1'b0;
        fq.in_taken0 = 1'b0;
        fq.flush     = 1'b0;
        fq.out_take  = 2'd0;
    endtask

    function automatic logic [31:0] cnt();
        return 32'(u_dut.r_count);
    endfunction

    initial begin
        fq.flush = 1'b0; fq.in_valid = 1'b0; fq.in_pc = '0;
        fq.in_instr0 = '0; fq.in_instr1 = '0; fq.in_taken0 = 1'b0; fq.in_taken1 = 1'b0;
        fq.in_target0 = '0; fq.in_target1 = '0; fq.out_take = 2'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid0", 32'(fq.out_valid0), 32'd0);
        check("rst_valid1", 32'(fq.out_valid1), 32'd0);
        check("rst_stall",  32'(fq.stall), 32'd0);
        check("rst_ovf",    32'(fq.ovf), 32'd0);
        check("rst_count",  cnt(), 32'd0);

        // Plain pair, no take
        drive_pair(32'h100, 1'b0);
        tick(); idle();
        check("pair_valid0", 32'(fq.out_valid0), 32'd1);
        check("pair_valid1", 32'(fq.out_valid1), 32'd1);
        check("pair_pc0",    fq.out_pc0, 32'h100);
        check("pair_pc1",    fq.out_pc1, 32'h104);
        check("pair_instr0", fq.out_instr0, 32'hA5A5_0100);
        check("pair_instr1", fq.out_instr1, 32'h5A5A_0104);
        check("pair_count",  cnt(), 32'd2);
        fq.out_take = 2'd2;
        tick(); idle();
        check("drain_count",  cnt(), 32'd0);
        check("drain_valid0", 32'(fq.out_valid0), 32'd0);

        // Predicted-taken slot 0 drops slot 1
        drive_pair(32'h200, 1'b1);
        fq.in_target0 = 32'h400;
        tick(); idle();
        check("tk_valid0", 32'(fq.out_valid0), 32'd1);
        check("tk_valid1", 32'(fq.out_valid1), 32'd0);
        check("tk_pc0",    fq.out_pc0, 32'h200);
        check("tk_target0", fq.out_target0, 32'h400);
        check("tk_taken0", 32'(fq.out_taken0), 32'd1);
        check("tk_count",  cnt(), 32'd1);
        fq.out_take = 2'd2;   // more than available: clamped
        tick(); idle();
        check("clamp_count", cnt(), 32'd0);

        // Fill with no consumption: stall at 12, two skid pairs fit, third overflows
        for (int i = 0; i < 6; i++) begin
            drive_pair(32'h1000 + 32'(8 * i), 1'b0);
            tick();
            if (i == 4) check("fill10_stall", 32'(fq.stall), 32'd0);
        end
        check("fill12_count", cnt(), 32'd12);
        check("fill12_stall", 32'(fq.stall), 32'd1);
        drive_pair(32'h1030, 1'b0); tick();
        drive_pair(32'h1038, 1'b0); tick();
        check("skid_count", cnt(), 32'd16);
        check("skid_ovf",   32'(fq.ovf), 32'd0);
        drive_pair(32'h1040, 1'b0); tick(); idle();
        check("ovf_count", cnt(), 32'd16);
        check("ovf_set",   32'(fq.ovf), 32'd1);
        check("full_pc0",  fq.out_pc0, 32'h1000);
        check("full_pc1",  fq.out_pc1, 32'h1004);

        // Flush, rebuild to 5, then flush with enqueue and dequeue pending
        fq.flush = 1'b1; tick(); idle();
        check("flush1_count", cnt(), 32'd0);
        drive_pair(32'h3000, 1'b0); tick();
        drive_pair(32'h3008, 1'b0); tick();
        drive_pair(32'h3010, 1'b1); tick(); idle();
        check("five_count", cnt(), 32'd5);
        drive_pair(32'h3018, 1'b0);
        fq.flush = 1'b1; fq.out_take = 2'd2;
        tick(); idle();
        check("flush_count",  cnt(), 32'd0);
        check("flush_valid0", 32'(fq.out_valid0), 32'd0);
        check("flush_stall",  32'(fq.stall), 32'd0);
        check("flush_ovf",    32'(fq.ovf), 32'd1);
        drive_pair(32'h500, 1'b0); tick(); idle();
        check("postflush_count", cnt(), 32'd2);
        check("postflush_pc0",   fq.out_pc0, 32'h500);

        // Steady state across pointer wrap
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst2_ovf", 32'(fq.ovf), 32'd0);
        drive_pair(32'h2000, 1'b0); tick();
        for (int k = 0; k < 20; k++) begin
            check("ss_pc0",   fq.out_pc0, 32'h2000 + 32'(8 * k));
            check("ss_pc1",   fq.out_pc1, 32'h2004 + 32'(8 * k));
            check("ss_count", cnt(), 32'd2);
            drive_pair(32'h2008 + 32'(8 * k), 1'b0);
            fq.out_take = 2'd2;
            tick();
        end
        idle();
        fq.flush = 1'b1; tick(); idle();

        // Empty queue, pair with take 1
        drive_pair(32'h300, 1'b0);
        fq.out_take = 2'd1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid0", 32'(fq.out_valid0), 32'd1);
        check("byp_pc0",    fq.out_pc0, 32'h300);
        tick(); idle();
        check("byp_count",  cnt(), 32'd1);
        check("byp_next_pc0", fq.out_pc0, 32'h304);
`else
        check("nobyp_valid0", 32'(fq.out_valid0), 32'd0);
        tick(); idle();
        check("nobyp_count",  cnt(), 32'd2);
        check("nobyp_pc0",    fq.out_pc0, 32'h300);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
